// File: rtl/cdiv_pkg.sv
// Shared constants and state encoding for the sequential complex divider.
package cdiv_pkg;

  localparam int N_DEF     = 32;
  localparam int Q_DEF     = 22;
  localparam int DIV_ITERS = N_DEF - 1;

  localparam logic [N_DEF-1:0] MAX_POS = {1'b0, {(N_DEF-1){1'b1}}};
  localparam logic [N_DEF-1:0] MAX_NEG = {1'b1, {(N_DEF-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIN,
    S_HOLD
  } state_t;

  function automatic int div_iters(input int n);
    return n - 1;
  endfunction

endpackage

// File: rtl/cdiv_seq_if.sv
// Operand/result handshake bundle for cdiv_seq.
interface cdiv_seq_if import cdiv_pkg::*; #(
  parameter int N = N_DEF
) ();
  logic                in_valid;
  logic                in_ready;
  logic signed [N-1:0] ar, ai, br, bi;
  logic                out_valid;
  logic                out_ready;
  logic signed [N-1:0] qr, qi;
  logic                dz;
  logic                ovr;

  modport master (
    output in_valid, ar, ai, br, bi, out_ready,
    input  in_ready, out_valid, qr, qi, dz, ovr
  );

  modport slave (
    input  in_valid, ar, ai, br, bi, out_ready,
    output in_ready, out_valid, qr, qi, dz, ovr
  );
endinterface

// File: rtl/udiv_step_seq.sv
// Restoring unsigned divider: floor(mag*2^Q / den) as an N-1 bit quotient, one bit per cycle.
module udiv_step_seq import cdiv_pkg::*; #(
  parameter int N = N_DEF,
  parameter int Q = Q_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [2*N-1:0] mag,
  input  logic [2*N-1:0] den,
  output logic           busy,
  output logic           done,
  output logic [N-2:0]   quo,
  output logic           ovf
);
  localparam int W    = 2*N;
  localparam int DW   = W + Q;
  localparam int HW   = N + Q + 1;
  localparam int CW   = $clog2(N);
  localparam int LAST = div_iters(N) - 1;

  logic [DW-1:0] dvd;
  logic [W-1:0]  hi_ext;
  logic [W-1:0]  rem_q, den_q;
  logic [N-2:0]  lo_q;
  logic [CW-1:0] cnt;
  logic [W:0]    trial;
  logic          fit;

  // The top N+Q+1 dividend bits seed the remainder; it is < den unless the result overflows.
  always_comb begin
    dvd    = {mag, {Q{1'b0}}};
    hi_ext = W'(dvd[DW-1 -: HW]);
    trial  = {rem_q, lo_q[N-2]};
    fit    = (trial >= {1'b0, den_q});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      den_q <= '0;
      lo_q  <= '0;
      quo   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem_q <= hi_ext;
        lo_q  <= dvd[N-2:0];
        den_q <= den;
        ovf   <= (hi_ext >= den);
        quo   <= '0;
        cnt   <= '0;
        busy  <= 1'b1;
      end else if (busy) begin
        rem_q <= fit ? W'(trial - {1'b0, den_q}) : trial[W-1:0];
        lo_q  <= {lo_q[N-3:0], 1'b0};
        quo   <= {quo[N-3:0], fit};
        cnt   <= cnt + 1'b1;
        if (cnt == CW'(LAST)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/cdiv_seq.sv
// Sequential Q-format complex divider q = a*conj(b)/|b|^2 with valid/ready on both sides.
module cdiv_seq import cdiv_pkg::*; #(
  parameter int N = N_DEF,
  parameter int Q = Q_DEF
) (
  input logic       clk,
  input logic       rst_n,
  cdiv_seq_if.slave bus
);
  localparam int W  = 2*N;
  localparam int W1 = W + 1;
  localparam logic [N-1:0] SAT_POS = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] SAT_NEG = {1'b1, {(N-1){1'b0}}};

  state_t state;

  logic signed [N-1:0] ar_q, ai_q, br_q, bi_q;
  logic [1:0]          sgn_q;
  logic                dz_q;

  logic signed [W-1:0]  p_rr, p_ii, p_ir, p_ri, p_bb_r, p_bb_i;
  logic signed [W1-1:0] num_r, num_i;
  logic [W-1:0]         den_u;
  logic [1:0][W-1:0]    mag;
  logic [1:0][N-2:0]    quo;
  logic [1:0][N-1:0]    res;
  logic [1:0]           busy, done, ovf;
  logic                 dv_start;

  always_comb begin
    p_rr   = W'(ar_q) * W'(br_q);
    p_ii   = W'(ai_q) * W'(bi_q);
    p_ir   = W'(ai_q) * W'(br_q);
    p_ri   = W'(ar_q) * W'(bi_q);
    p_bb_r = W'(br_q) * W'(br_q);
    p_bb_i = W'(bi_q) * W'(bi_q);
    num_r  = W1'(p_rr) + W1'(p_ii);
    num_i  = W1'(p_ir) - W1'(p_ri);
    // Sum of squares never exceeds 2^(2N-1), so it fits unsigned in 2N bits.
    den_u  = $unsigned(p_bb_r) + $unsigned(p_bb_i);
    mag[0] = num_r[W] ? W'(-num_r) : W'(num_r);
    mag[1] = num_i[W] ? W'(-num_i) : W'(num_i);
  end

  assign dv_start = (state == S_MUL) && !(|busy);

  for (genvar i = 0; i < 2; i++) begin : g_lane
    udiv_step_seq #(.N(N), .Q(Q)) u_div (
      .clk   (clk),
      .rst_n (rst_n),
      .start (dv_start),
      .mag   (mag[i]),
      .den   (den_u),
      .busy  (busy[i]),
      .done  (done[i]),
      .quo   (quo[i]),
      .ovf   (ovf[i])
    );
  end

  // Negating a zero magnitude yields 0, so -0 never appears.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      res[i] = '0;
      if (!dz_q) begin
        if (ovf[i])        res[i] = sgn_q[i] ? SAT_NEG : SAT_POS;
        else if (sgn_q[i]) res[i] = -{1'b0, quo[i]};
        else               res[i] = {1'b0, quo[i]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      ar_q          <= '0;
      ai_q          <= '0;
      br_q          <= '0;
      bi_q          <= '0;
      sgn_q         <= '0;
      dz_q          <= 1'b0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.qr        <= '0;
      bus.qi        <= '0;
      bus.dz        <= 1'b0;
      bus.ovr       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (bus.in_valid) begin
          ar_q         <= bus.ar;
          ai_q         <= bus.ai;
          br_q         <= bus.br;
          bi_q         <= bus.bi;
          bus.in_ready <= 1'b0;
          state        <= S_MUL;
        end
        S_MUL: begin
          sgn_q <= {num_i[W], num_r[W]};
          dz_q  <= (den_u == '0);
          state <= S_DIV;
        end
        // A zero divisor still runs the iteration count so latency stays fixed.
        S_DIV: if (&done) state <= S_FIN;
        S_FIN: begin
          bus.qr        <= res[0];
          bus.qi        <= res[1];
          bus.dz        <= dz_q;
          bus.ovr       <= !dz_q && (|ovf);
          bus.out_valid <= 1'b1;
          state         <= S_HOLD;
        end
        S_HOLD: if (bus.out_ready) begin
          bus.out_valid <= 1'b0;
          bus.dz        <= 1'b0;
          bus.ovr       <= 1'b0;
          bus.in_ready  <= 1'b1;
          state         <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cdiv_seq.sv
// Directed vector bench for cdiv_seq: results, latency, backpressure and async reset.
module tb_cdiv_seq;
  import cdiv_pkg::*;

  typedef struct {
    string       name;
    logic [31:0] ar, ai, br, bi;
    logic [31:0] qr, qi;
    logic        dz, ovr;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  vec_t vt[7];

  always #5 clk = ~clk;

  cdiv_seq_if #(.N(32)) bus ();

  cdiv_seq #(.N(32), .Q(22)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s actual=%h required=%h", nm, act, exp);
    else pass_cnt++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input vec_t v);
    bus.ar       = v.ar;
    bus.ai       = v.ai;
    bus.br       = v.br;
    bus.bi       = v.bi;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat, output int rdy_bad);
    lat     = 0;
    rdy_bad = 0;
    while (bus.out_valid !== 1'b1 && lat < 200) begin
      if (bus.in_ready !== 1'b0) rdy_bad++;
      step();
      lat++;
    end
  endtask

  task automatic check_vec(input vec_t v);
    int lat, rdy_bad;
    start_op(v);
    wait_result(lat, rdy_bad);
    chk({v.name, " latency"},  32'(lat), 32'd34);
    chk({v.name, " busy_rdy"}, 32'(rdy_bad), 32'd0);
    chk({v.name, " qr"},  bus.qr, v.qr);
    chk({v.name, " qi"},  bus.qi, v.qi);
    chk({v.name, " dz"},  32'(bus.dz), 32'(v.dz));
    chk({v.name, " ovr"}, 32'(bus.ovr), 32'(v.ovr));
  endtask

  task automatic ack(input string nm);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk({nm, " ack out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({nm, " ack in_ready"},  32'(bus.in_ready), 32'd1);
    chk({nm, " ack dz"},        32'(bus.dz), 32'd0);
    chk({nm, " ack ovr"},       32'(bus.ovr), 32'd0);
  endtask

  initial begin
    int bad_stable, bad_rdy, bad_vld, lat, rdy_bad;
    logic [31:0] hold_qr, hold_qi;

    vt[0] = '{"one_over_one", 32'h0040_0000, 32'h0040_0000, 32'h0040_0000, 32'h0040_0000,
              32'h0040_0000, 32'h0000_0000, 1'b0, 1'b0};
    vt[1] = '{"one_over_j",   32'h0040_0000, 32'h0000_0000, 32'h0000_0000, 32'h0040_0000,
              32'h0000_0000, 32'hFFC0_0000, 1'b0, 1'b0};
    vt[2] = '{"one_third",    32'h0040_0000, 32'h0000_0000, 32'h00C0_0000, 32'h0000_0000,
              32'h0015_5555, 32'h0000_0000, 1'b0, 1'b0};
    vt[3] = '{"neg_third",    32'hFFC0_0000, 32'h0000_0000, 32'h00C0_0000, 32'h0000_0000,
              32'hFFEA_AAAB, 32'h0000_0000, 1'b0, 1'b0};
    vt[4] = '{"mixed_half",   32'hFFA0_0000, 32'h0020_0000, 32'h0020_0000, 32'h0000_0000,
              32'hFF40_0000, 32'h0040_0000, 1'b0, 1'b0};
    vt[5] = '{"div_zero",     32'h0040_0000, 32'h0040_0000, 32'h0000_0000, 32'h0000_0000,
              32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0};
    vt[6] = '{"overflow",     32'h4000_0000, 32'hC000_0000, 32'h0000_1000, 32'h0000_0000,
              MAX_POS, MAX_NEG, 1'b0, 1'b1};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.ar        = '0;
    bus.ai        = '0;
    bus.br        = '0;
    bus.bi        = '0;
    step();
    step();
    chk("reset in_ready",  32'(bus.in_ready), 32'd1);
    chk("reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset qr", bus.qr, 32'd0);
    chk("reset qi", bus.qi, 32'd0);
    chk("reset dz", 32'(bus.dz), 32'd0);
    chk("reset ovr", 32'(bus.ovr), 32'd0);
    rst_n = 1'b1;
    step();

    // out_ready held high while idle must not produce anything
    bus.out_ready = 1'b1;
    bad_vld = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) bad_vld++;
    end
    bus.out_ready = 1'b0;
    chk("idle out_ready", 32'(bad_vld), 32'd0);

    for (int i = 0; i < 7; i++) begin
      check_vec(vt[i]);
      ack(vt[i].name);
    end

    // Backpressure: result held for 20 cycles while foreign operands are offered
    start_op(vt[2]);
    wait_result(lat, rdy_bad);
    chk("bp latency", 32'(lat), 32'd34);
    hold_qr    = bus.qr;
    hold_qi    = bus.qi;
    chk("bp qr", hold_qr, 32'h0015_5555);
    bad_stable = 0;
    bad_rdy    = 0;
    bad_vld    = 0;
    for (int i = 0; i < 20; i++) begin
      bus.in_valid = i[0];
      bus.ar       = 32'h0123_4567 + 32'(i);
      bus.br       = 32'h0040_0000;
      bus.bi       = 32'h0000_0000;
      step();
      if (bus.qr !== hold_qr || bus.qi !== hold_qi) bad_stable++;
      if (bus.in_ready !== 1'b0) bad_rdy++;
      if (bus.out_valid !== 1'b1) bad_vld++;
    end
    bus.in_valid = 1'b0;
    chk("bp stable",    32'(bad_stable), 32'd0);
    chk("bp in_ready",  32'(bad_rdy), 32'd0);
    chk("bp out_valid", 32'(bad_vld), 32'd0);
    ack("bp");
    bad_vld = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.out_valid !== 1'b0) bad_vld++;
    end
    chk("bp no stray op", 32'(bad_vld), 32'd0);

    // Async reset in the middle of the divide loop
    start_op(vt[0]);
    for (int i = 0; i < 9; i++) step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst in_ready",  32'(bus.in_ready), 32'd1);
    chk("arst qr", bus.qr, 32'd0);
    chk("arst qi", bus.qi, 32'd0);
    step();
    rst_n = 1'b1;
    bad_vld = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.out_valid !== 1'b0) bad_vld++;
    end
    chk("arst aborted", 32'(bad_vld), 32'd0);
    check_vec(vt[4]);
    ack("post_arst");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
